// File: rtl/fault_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : fault_qualifier
// Purpose  : Synchronises and debounces a raw fault sensor line into a clean,
//            registered true_fault level. A fault is declared only after a
//            programmable run of active samples and released after a run of
//            inactive samples, or held until acknowledged in latched mode.
//            Aborted candidates are counted (saturating) for diagnostics.
// Revision : 1.0 - initial release
// ============================================================================
module fault_qualifier #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CLEAR_CYCLES    = 16,
  parameter int CNT_W           = 16,
  parameter int LATCH           = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_fault,
  input  logic       fault_ack,
  output logic       true_fault,
  output logic       fault_pending,
  output logic [7:0] glitch_count
);

  // State encoding
  localparam logic [1:0] C_ST_IDLE     = 2'd0;
  localparam logic [1:0] C_ST_PENDING  = 2'd1;
  localparam logic [1:0] C_ST_FAULT    = 2'd2;
  localparam logic [1:0] C_ST_CLEARING = 2'd3;

  // Terminal counts; the compare ends each run before the counter can wrap.
  localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       C_GL_MAX   = 8'hFF;

  logic             s1_q, s1_d;
  logic             s_q, s_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             true_fault_q, true_fault_d;
  logic             fault_pending_q, fault_pending_d;
  logic [7:0]       glitch_q, glitch_d;

  // Next-state logic: synchroniser shift, qualification FSM and output decode
  always_comb begin
    s1_d     = raw_fault;
    s_d      = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;

    case (state_q)
      C_ST_IDLE: begin
        if (s_q) begin
          state_d = C_ST_PENDING;
          cnt_d   = C_CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      C_ST_PENDING: begin
        if (!s_q) begin
          // Candidate aborted before qualifying: record one glitch.
          state_d = C_ST_IDLE;
          cnt_d   = '0;
          if (glitch_q != C_GL_MAX) begin
            glitch_d = glitch_q + 8'd1;
          end
        end else if (cnt_q == C_DEB_LAST) begin
          state_d = C_ST_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end

      C_ST_FAULT: begin
        if (LATCH != 0) begin
          // Acknowledge only takes effect once the line is already quiet.
          if (fault_ack && !s_q) begin
            state_d = C_ST_IDLE;
            cnt_d   = '0;
          end
        end else if (!s_q) begin
          state_d = C_ST_CLEARING;
          cnt_d   = C_CNT_ONE;
        end
      end

      default: begin // C_ST_CLEARING
        if (s_q) begin
          // Bounce while releasing is not a glitch; fault simply persists.
          state_d = C_ST_FAULT;
          cnt_d   = '0;
        end else if (cnt_q == C_CLR_LAST) begin
          state_d = C_ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_CNT_ONE;
        end
      end
    endcase

    // Outputs decode the next state so they change on the same edge as it.
    true_fault_d    = (state_d == C_ST_FAULT) || (state_d == C_ST_CLEARING);
    fault_pending_d = (state_d == C_ST_PENDING);
  end

  // State registers with synchronous, highest-priority reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q            <= 1'b0;
      s_q             <= 1'b0;
      state_q         <= C_ST_IDLE;
      cnt_q           <= '0;
      true_fault_q    <= 1'b0;
      fault_pending_q <= 1'b0;
      glitch_q        <= 8'd0;
    end else begin
      s1_q            <= s1_d;
      s_q             <= s_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      true_fault_q    <= true_fault_d;
      fault_pending_q <= fault_pending_d;
      glitch_q        <= glitch_d;
    end
  end

  assign true_fault    = true_fault_q;
  assign fault_pending = fault_pending_q;
  assign glitch_count  = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_fault_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_qualifier
// Purpose  : Directed self-checking bench for fault_qualifier with
//            DEBOUNCE_CYCLES=4, CLEAR_CYCLES=3; one auto-release instance and
//            one latched instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fault_qualifier;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw = 1'b0;
  logic       ack = 1'b0;
  logic       tf;
  logic       pend;
  logic [7:0] gl;

  logic       raw_l = 1'b0;
  logic       ack_l = 1'b0;
  logic       tf_l;
  logic       pend_l;
  logic [7:0] gl_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fault_qualifier #(
    .DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(3), .CNT_W(16), .LATCH(0)
  ) u_dut (
    .clk(clk), .reset(reset), .raw_fault(raw), .fault_ack(ack),
    .true_fault(tf), .fault_pending(pend), .glitch_count(gl)
  );

  fault_qualifier #(
    .DEBOUNCE_CYCLES(4), .CLEAR_CYCLES(3), .CNT_W(16), .LATCH(1)
  ) u_lat (
    .clk(clk), .reset(reset), .raw_fault(raw_l), .fault_ack(ack_l),
    .true_fault(tf_l), .fault_pending(pend_l), .glitch_count(gl_l)
  );

  // Advance one active edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held with raw high, then full assert latency after release.
  task automatic test_reset();
    reset = 1'b1;
    raw   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_tests++;
      if ({tf, pend, gl} !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: tf=%b pend=%b gl=%0d, want 0/0/0", k, tf, pend, gl);
      end
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (tf !== (k >= 6) || pend !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL reset_release edge%0d: tf=%b pend=%b, want %b/%b", k, tf, pend, k >= 6, k >= 3 && k <= 5);
      end
    end
    raw = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_tests++;
    if (tf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cleanup: tf=%b, want 0", tf);
    end
  endtask

  // Clean fault: assert at edge 6, release at edge 5 of the low period.
  task automatic test_clean_fault();
    raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_tests++;
      if (tf !== (k >= 6) || pend !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL clean_assert edge%0d: tf=%b pend=%b, want %b/%b", k, tf, pend, k >= 6, k >= 3 && k <= 5);
      end
    end
    raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_tests++;
      if (tf !== (k < 5) || pend !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_release edge%0d: tf=%b pend=%b, want %b/0", k, tf, pend, k < 5);
      end
    end
    n_tests++;
    if (gl !== 8'd0) begin
      n_fail++;
      $display("FAIL clean_glitch: gl=%0d, want 0", gl);
    end
  endtask

  // 2-cycle pulses abort in PENDING; count each once, saturate at 255.
  task automatic test_glitches();
    for (int p = 1; p <= 260; p++) begin
      raw = 1'b1;
      step();
      step();
      raw = 1'b0;
      for (int k = 0; k < 6; k++) begin
        step();
        if (p <= 5) begin
          n_tests++;
          if (tf !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_tf pulse%0d: tf=%b, want 0", p, tf);
          end
        end
      end
      if (p <= 5 || p == 254 || p == 255 || p == 260) begin
        n_tests++;
        if (gl !== ((p > 255) ? 8'd255 : 8'(p))) begin
          n_fail++;
          $display("FAIL glitch_count pulse%0d: gl=%0d, want %0d", p, gl, (p > 255) ? 255 : p);
        end
      end
    end
    n_tests++;
    if (tf !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_sat_tf: tf=%b, want 0", tf);
    end
  endtask

  // Short low bounce while in FAULT must not drop true_fault.
  task automatic test_bounce_clearing();
    reset = 1'b1;
    step();
    reset = 1'b0;
    raw = 1'b1;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (tf !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_setup: tf=%b, want 1", tf);
    end
    raw = 1'b0;
    step();
    step();
    raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (tf !== 1'b1 || pend !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_hold cyc%0d: tf=%b pend=%b, want 1/0", k, tf, pend);
      end
    end
    n_tests++;
    if (gl !== 8'd0) begin
      n_fail++;
      $display("FAIL bounce_glitch: gl=%0d, want 0", gl);
    end
    raw = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (tf !== (k < 5)) begin
        n_fail++;
        $display("FAIL bounce_release edge%0d: tf=%b, want %b", k, tf, k < 5);
      end
    end
  endtask

  // Latched instance: hold after release, ack ignored while line active.
  task automatic test_latched();
    raw_l = 1'b1;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (tf_l !== 1'b1) begin
      n_fail++;
      $display("FAIL latch_assert: tf=%b, want 1", tf_l);
    end
    raw_l = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_tests++;
      if (tf_l !== 1'b1) begin
        n_fail++;
        $display("FAIL latch_hold cyc%0d: tf=%b, want 1", k, tf_l);
      end
    end
    raw_l = 1'b1;
    for (int k = 0; k < 3; k++) step();
    ack_l = 1'b1;
    step();
    ack_l = 1'b0;
    n_tests++;
    if (tf_l !== 1'b1) begin
      n_fail++;
      $display("FAIL latch_ack_active: tf=%b, want 1", tf_l);
    end
    raw_l = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      n_tests++;
      if (tf_l !== 1'b1) begin
        n_fail++;
        $display("FAIL latch_ack_not_remembered cyc%0d: tf=%b, want 1", k, tf_l);
      end
    end
    ack_l = 1'b1;
    step();
    ack_l = 1'b0;
    n_tests++;
    if (tf_l !== 1'b0 || pend_l !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_ack_release: tf=%b pend=%b, want 0/0", tf_l, pend_l);
    end
  endtask

  // One-cycle reset mid-PENDING and mid-CLEARING; full latency afterwards.
  task automatic test_mid_reset();
    raw = 1'b1;
    step();
    step();
    raw = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_tests++;
    if (gl !== 8'd1) begin
      n_fail++;
      $display("FAIL midrst_glitch_setup: gl=%0d, want 1", gl);
    end
    raw = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_tests++;
    if (pend !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pending_setup: pend=%b, want 1", pend);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if ({tf, pend, gl} !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_pending: tf=%b pend=%b gl=%0d, want 0/0/0", tf, pend, gl);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (tf !== (k >= 6)) begin
        n_fail++;
        $display("FAIL midrst_pending_relat edge%0d: tf=%b, want %b", k, tf, k >= 6);
      end
    end
    raw = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_tests++;
    if (tf !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_clearing_setup: tf=%b, want 1", tf);
    end
    reset = 1'b1;
    raw   = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if ({tf, pend, gl} !== 10'd0) begin
      n_fail++;
      $display("FAIL midrst_clearing: tf=%b pend=%b gl=%0d, want 0/0/0", tf, pend, gl);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      n_tests++;
      if (tf !== (k >= 6) || pend !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL midrst_clearing_relat edge%0d: tf=%b pend=%b, want %b/%b", k, tf, pend, k >= 6, k >= 3 && k <= 5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_fault();
    test_glitches();
    test_bounce_clearing();
    test_latched();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
